wr_chan_sched: RTL and testbench

Write-channel scheduler for the AXI master side. It arbitrates between two write requesters, such as the data-cache writeback and the DMA/UART path, each supplying one 4-beat 128-bit burst. It drives the AW channel, launches the write data channel manager through its next_rq/next_id/next_addr/in_wdata interface, collects the B response and reports completion to the granted requester. Exactly one write transaction is in flight at a time.

---
 rtl/wr_chan_sched.sv | 161 ++++++++++++++++
 tb/tb_wr_chan_sched.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_chan_sched.sv
// wr_chan_sched: AXI write-channel scheduler for two burst requesters.
// Arbitrates round-robin between two 4-beat x 32-bit (128-bit) write bursts.
// It issues AW, starts the write-data manager, then waits for the B response
// and reports completion to the granted requester. Only one transaction is
// in flight at a time.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rqN_req/addr/wdata    requester N burst request (held until rqN_ack)
//   rqN_ack               1-cycle pulse when the request is latched
//   rqN_done/err          1-cycle completion pulse; err qualifies done
//   awvalid/awready/awid/awaddr/awlen   AXI AW channel (awlen fixed at 3)
//   next_rq/next_id/next_addr/in_wdata  write-data manager launch interface
//   finish_wd             data manager: last beat accepted
//   bvalid/bready/bid/bresp             AXI B channel
module wr_chan_sched #(
  parameter logic [3:0]  ID_BASE   = 4'd0,
  parameter logic [15:0] B_TIMEOUT = 16'd1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rq0_req,
  input  logic [31:0]  rq0_addr,
  input  logic [127:0] rq0_wdata,
  output logic         rq0_ack,
  output logic         rq0_done,
  output logic         rq0_err,
  input  logic         rq1_req,
  input  logic [31:0]  rq1_addr,
  input  logic [127:0] rq1_wdata,
  output logic         rq1_ack,
  output logic         rq1_done,
  output logic         rq1_err,
  output logic         awvalid,
  input  logic         awready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         next_rq,
  output logic [3:0]   next_id,
  output logic [31:0]  next_addr,
  output logic [127:0] in_wdata,
  input  logic         finish_wd,
  input  logic         bvalid,
  output logic         bready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_WD, S_BR} state_t;

  typedef struct packed {
    logic         sel;
    logic [3:0]   id;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } wr_req_t;

  state_t                 state, state_nxt;
  wr_req_t                cur;
  logic                   last_gnt, wd_first;
  logic [15:0]            b_cnt;
  logic [1:0]             req, ack, done;
  logic [1:0][31:0]       req_addr;
  logic [1:0][127:0]      req_wdata;
  logic                   gnt_sel, grant, b_tmo, b_end, b_err;

  assign req       = {rq1_req, rq0_req};
  assign req_addr  = {rq1_addr, rq0_addr};
  assign req_wdata = {rq1_wdata, rq0_wdata};
  assign awlen     = 8'd3;

  always_comb begin
    state_nxt = state;
    // on a tie the requester not granted last wins
    gnt_sel   = (&req) ? ~last_gnt : req[1];
    grant     = 1'b0;
    ack       = '0;
    done      = '0;
    b_tmo     = 1'b0;
    b_end     = 1'b0;
    b_err     = 1'b0;
    awvalid   = 1'b0;
    awid      = '0;
    awaddr    = '0;
    next_rq   = 1'b0;
    next_id   = '0;
    next_addr = '0;
    in_wdata  = '0;
    bready    = 1'b0;
    case (state)
      S_IDLE: begin
        // ack is combinational; qualifying with rst_n keeps it low during reset
        if (rst_n && (|req)) begin
          grant        = 1'b1;
          ack[gnt_sel] = 1'b1;
          state_nxt    = S_AW;
        end
      end
      S_AW: begin
        awvalid = 1'b1;
        awid    = cur.id;
        awaddr  = cur.addr;
        if (awready) state_nxt = S_WD;
      end
      S_WD: begin
        next_rq   = wd_first;
        next_id   = cur.id;
        next_addr = cur.addr;
        in_wdata  = cur.wdata;
        if (finish_wd) state_nxt = S_BR;
      end
      S_BR: begin
        bready    = 1'b1;
        next_id   = cur.id;
        next_addr = cur.addr;
        in_wdata  = cur.wdata;
        b_tmo     = !bvalid && (b_cnt == B_TIMEOUT);
        b_end     = bvalid || b_tmo;
        // a response for some other ID is treated as an error completion
        b_err     = b_tmo || bresp[1] || (bid != cur.id);
        if (b_end) begin
          done[cur.sel] = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rq0_ack  = ack[0];
  assign rq1_ack  = ack[1];
  assign rq0_done = done[0];
  assign rq1_done = done[1];
  assign rq0_err  = done[0] & b_err;
  assign rq1_err  = done[1] & b_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      last_gnt <= 1'b1;
      wd_first <= 1'b0;
      b_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      // marks the first S_WD cycle so next_rq is a single pulse
      wd_first <= (state == S_AW) && awready;
      // held at zero outside S_BR so it starts from 0 on entry
      b_cnt    <= (state == S_BR) ? b_cnt + 16'd1 : '0;
      if (grant) begin
        last_gnt  <= gnt_sel;
        cur.sel   <= gnt_sel;
        cur.id    <= ID_BASE + {3'b000, gnt_sel};
        cur.addr  <= req_addr[gnt_sel];
        cur.wdata <= req_wdata[gnt_sel];
      end
    end
  end

endmodule

// File: tb/tb_wr_chan_sched.sv
// Self-checking bench for wr_chan_sched. The bench plays the AXI slave and
// the write-data manager per transaction. A round-robin reference model
// predicts the winner, ID, latched address/data and error flag.
module tb_wr_chan_sched;

  localparam logic [3:0]  ID_B = 4'hF;   // requester 1 ID wraps to 0
  localparam logic [15:0] B_TO = 16'd40;

  logic         clk, rst_n;
  logic         rq0_req, rq1_req;
  logic [31:0]  rq0_addr, rq1_addr;
  logic [127:0] rq0_wdata, rq1_wdata;
  logic         rq0_ack, rq0_done, rq0_err, rq1_ack, rq1_done, rq1_err;
  logic         awvalid, awready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic         next_rq;
  logic [3:0]   next_id;
  logic [31:0]  next_addr;
  logic [127:0] in_wdata;
  logic         finish_wd, bvalid, bready;
  logic [3:0]   bid;
  logic [1:0]   bresp;

  int total = 0;
  int bad   = 0;
  int last_gnt = 1;

  wr_chan_sched #(.ID_BASE(ID_B), .B_TIMEOUT(B_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_ack(rq0_ack), .rq0_done(rq0_done), .rq0_err(rq0_err),
    .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_ack(rq1_ack), .rq1_done(rq1_done), .rq1_err(rq1_err),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .next_rq(next_rq), .next_id(next_id), .next_addr(next_addr), .in_wdata(in_wdata),
    .finish_wd(finish_wd), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit           ack_ok;
    int           sel;
    int           n_awv;
    bit           aw_stable;
    logic [31:0]  awaddr;
    logic [3:0]   awid;
    logic [7:0]   awlen;
    int           n_nrq;
    bit           nrq_first;
    logic [3:0]   nid;
    logic [31:0]  naddr;
    logic [127:0] nwdata;
    int           n_nobr;
    bit           done_ok;
    int           done_sel;
    bit           err;
    int           inv;
  } obs_t;

  // reference model: round-robin pick, pointer starts at 1 after reset
  function automatic int arb(input bit r0, input bit r1);
    int w;
    if (r0 && r1) w = 1 - last_gnt;
    else          w = r1 ? 1 : 0;
    last_gnt = w;
    return w;
  endfunction

  function automatic logic [3:0] exp_id(input int w);
    return ID_B + ((w == 1) ? 4'd1 : 4'd0);
  endfunction

  function automatic logic any_out();
    return |{rq0_ack, rq0_done, rq0_err, rq1_ack, rq1_done, rq1_err, awvalid, awid,
             awaddr, next_rq, next_id, next_addr, in_wdata, bready};
  endfunction

  // Runs one transaction from its IDLE cycle to its done cycle. Entered and
  // left at posedge+1; the phase lengths follow the protocol rules. Inputs
  // are driven at posedge+1 and outputs are sampled 1 time unit later.
  task automatic txn(input int aw_wait, input int wd_dly, input int b_dly,
                     input logic [1:0] resp, input logic [3:0] bid_v,
                     input bit tmo, input bit hold, output obs_t o);
    int nbr;
    o = '{default: 0};
    o.aw_stable = 1'b1;
    nbr = tmo ? int'(B_TO) : b_dly;
    #1;
    o.ack_ok = rq0_ack ^ rq1_ack;
    o.sel    = rq1_ack ? 1 : 0;
    if (rq0_done | rq1_done | awvalid | next_rq | bready) o.inv++;
    @(posedge clk); #1;
    if (!hold) begin
      if (o.sel == 1) rq1_req = 1'b0; else rq0_req = 1'b0;
    end
    for (int i = 0; i <= aw_wait; i++) begin
      awready = (i == aw_wait);
      #1;
      if (i == 0) begin
        o.awaddr = awaddr; o.awid = awid; o.awlen = awlen;
      end else if (awaddr !== o.awaddr || awid !== o.awid) o.aw_stable = 1'b0;
      if (awvalid) o.n_awv++;
      if (next_rq | bready | rq0_ack | rq1_ack | rq0_done | rq1_done) o.inv++;
      @(posedge clk); #1;
    end
    awready = 1'b0;
    for (int j = 0; j <= wd_dly; j++) begin
      finish_wd = (j == wd_dly);
      #1;
      if (j == 0) begin
        o.nrq_first = next_rq; o.nid = next_id; o.naddr = next_addr; o.nwdata = in_wdata;
      end
      if (next_rq) o.n_nrq++;
      if (awvalid | bready | rq0_ack | rq1_ack | rq0_done | rq1_done) o.inv++;
      @(posedge clk); #1;
    end
    finish_wd = 1'b0;
    for (int k = 0; k <= nbr; k++) begin
      bvalid = !tmo && (k == nbr);
      bresp  = resp;
      bid    = bid_v;
      #1;
      if (!bready) o.n_nobr++;
      if (k == nbr) begin
        o.done_ok  = rq0_done ^ rq1_done;
        o.done_sel = rq1_done ? 1 : 0;
        o.err      = rq0_err | rq1_err;
      end else if (rq0_done | rq1_done) o.inv++;
      if (awvalid | next_rq | rq0_ack | rq1_ack) o.inv++;
      @(posedge clk); #1;
    end
    bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
  endtask

  task automatic test_reset();
    rq0_req = 1'b1; rq1_req = 1'b1; awready = 1'b1; finish_wd = 1'b1; bvalid = 1'b1;
    #3;
    total++;
    if (any_out() !== 1'b0) begin bad++; $display("FAIL reset_outs got=%b want=0", any_out()); end
    total++;
    if (awlen !== 8'd3) begin bad++; $display("FAIL reset_awlen got=%0d want=3", awlen); end
    rq0_req = 1'b0; rq1_req = 1'b0; awready = 1'b0; finish_wd = 1'b0; bvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_gnt = 1;
    @(posedge clk); #1;
    total++;
    if (any_out() !== 1'b0) begin bad++; $display("FAIL idle_outs got=%b want=0", any_out()); end
  endtask

  task automatic test_first_tie();
    obs_t o; int w;
    rq0_addr = 32'h0000_2000; rq0_wdata = {4{32'hA5A5_0000}};
    rq1_addr = 32'h0000_3000; rq1_wdata = {4{32'h5A5A_1111}};
    rq0_req = 1'b1; rq1_req = 1'b1;
    w = arb(1, 1);
    txn(0, 1, 0, 2'b00, exp_id(w), 0, 0, o);
    total++;
    if (o.sel !== w) begin bad++; $display("FAIL tie_first_sel got=%0d want=%0d", o.sel, w); end
    total++;
    if (o.awid !== exp_id(w)) begin bad++; $display("FAIL tie_first_awid got=%h want=%h", o.awid, exp_id(w)); end
    // requester 1 still holding: granted in the very next IDLE cycle
    w = arb(0, 1);
    txn(0, 0, 1, 2'b00, exp_id(w), 0, 0, o);
    total++;
    if (o.ack_ok !== 1'b1 || o.sel !== w) begin
      bad++; $display("FAIL b2b_sel ack=%0d got=%0d want=%0d", o.ack_ok, o.sel, w);
    end
    total++;
    if (o.awid !== exp_id(w)) begin bad++; $display("FAIL b2b_awid_wrap got=%h want=%h", o.awid, exp_id(w)); end
    total++;
    if (o.inv !== 0) begin bad++; $display("FAIL b2b_inv got=%0d want=0", o.inv); end
  endtask

  task automatic test_single();
    obs_t o; int w;
    logic [127:0] d;
    d = 128'h44444444_33333333_22222222_11111111;
    rq0_addr = 32'h0000_1000; rq0_wdata = d; rq0_req = 1'b1;
    w = arb(1, 0);
    txn(0, 4, 0, 2'b00, exp_id(w), 0, 0, o);
    total++; if (o.ack_ok !== 1'b1) begin bad++; $display("FAIL single_ack got=%0d want=1", o.ack_ok); end
    total++; if (o.sel !== w) begin bad++; $display("FAIL single_sel got=%0d want=%0d", o.sel, w); end
    total++; if (o.n_awv !== 1) begin bad++; $display("FAIL single_awv_cycles got=%0d want=1", o.n_awv); end
    total++; if (o.awaddr !== 32'h1000) begin bad++; $display("FAIL single_awaddr got=%h want=1000", o.awaddr); end
    total++; if (o.awid !== ID_B) begin bad++; $display("FAIL single_awid got=%h want=%h", o.awid, ID_B); end
    total++; if (o.awlen !== 8'd3) begin bad++; $display("FAIL single_awlen got=%0d want=3", o.awlen); end
    total++; if (o.n_nrq !== 1 || o.nrq_first !== 1'b1) begin
      bad++; $display("FAIL single_next_rq count=%0d first=%0d want 1/1", o.n_nrq, o.nrq_first);
    end
    total++; if (o.nwdata !== d) begin bad++; $display("FAIL single_wdata got=%h want=%h", o.nwdata, d); end
    total++; if (o.naddr !== 32'h1000 || o.nid !== ID_B) begin
      bad++; $display("FAIL single_next_addr_id got=%h/%h want=1000/%h", o.naddr, o.nid, ID_B);
    end
    total++; if (o.done_ok !== 1'b1 || o.done_sel !== 0) begin
      bad++; $display("FAIL single_done ok=%0d sel=%0d want 1/0", o.done_ok, o.done_sel);
    end
    total++; if (o.err !== 1'b0) begin bad++; $display("FAIL single_err got=%0d want=0", o.err); end
    total++; if (o.inv !== 0 || o.n_nobr !== 0) begin
      bad++; $display("FAIL single_protocol inv=%0d nobready=%0d want 0/0", o.inv, o.n_nobr);
    end
  endtask

  task automatic test_round_robin();
    obs_t o; int w;
    logic [31:0] ea;
    rq0_addr = $urandom; rq0_wdata = {$urandom, $urandom, $urandom, $urandom};
    rq1_addr = $urandom; rq1_wdata = {$urandom, $urandom, $urandom, $urandom};
    rq0_req = 1'b1; rq1_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
      w  = arb(1, 1);
      ea = (w == 1) ? rq1_addr : rq0_addr;
      txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), 2'b00, exp_id(w), 0, 1, o);
      total++; if (o.sel !== w) begin bad++; $display("FAIL rr_sel[%0d] got=%0d want=%0d", n, o.sel, w); end
      total++; if (o.awid !== exp_id(w) || o.awaddr !== ea) begin
        bad++; $display("FAIL rr_aw[%0d] got=%h/%h want=%h/%h", n, o.awid, o.awaddr, exp_id(w), ea);
      end
      total++; if (o.done_sel !== w || o.err !== 1'b0 || o.inv !== 0) begin
        bad++; $display("FAIL rr_done[%0d] sel=%0d err=%0d inv=%0d want %0d/0/0", n, o.done_sel, o.err, o.inv, w);
      end
    end
    rq0_req = 1'b0; rq1_req = 1'b0;
  endtask

  task automatic test_backpressure();
    obs_t o; int w;
    rq1_addr = 32'hDEAD_BEE0; rq1_wdata = {$urandom, $urandom, $urandom, $urandom}; rq1_req = 1'b1;
    w = arb(0, 1);
    txn(5, $urandom_range(0, 3), 1, 2'b00, exp_id(w), 0, 0, o);
    total++; if (o.n_awv !== 6) begin bad++; $display("FAIL bp_awv_cycles got=%0d want=6", o.n_awv); end
    total++; if (o.aw_stable !== 1'b1 || o.awaddr !== 32'hDEAD_BEE0) begin
      bad++; $display("FAIL bp_aw_stable stable=%0d addr=%h want 1/deadbee0", o.aw_stable, o.awaddr);
    end
    total++; if (o.inv !== 0) begin bad++; $display("FAIL bp_inv got=%0d want=0", o.inv); end
    total++; if (o.n_nrq !== 1 || o.nrq_first !== 1'b1) begin
      bad++; $display("FAIL bp_next_rq count=%0d first=%0d want 1/1", o.n_nrq, o.nrq_first);
    end
  endtask

  task automatic test_errors();
    obs_t o; int w;
    logic [1:0] rsp [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    bit         bdi [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit         xer [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int n = 0; n < 4; n++) begin
      rq0_addr = $urandom; rq0_wdata = {$urandom, $urandom, $urandom, $urandom}; rq0_req = 1'b1;
      w = arb(1, 0);
      txn(0, 0, $urandom_range(0, 2), rsp[n], bdi[n] ? (exp_id(w) ^ 4'h5) : exp_id(w), 0, 0, o);
      total++; if (o.done_ok !== 1'b1 || o.err !== xer[n]) begin
        bad++; $display("FAIL err_case[%0d] done=%0d err=%0d want 1/%0d", n, o.done_ok, o.err, xer[n]);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o; int w;
    rq0_addr = $urandom; rq0_wdata = {$urandom, $urandom, $urandom, $urandom}; rq0_req = 1'b1;
    w = arb(1, 0);
    txn(0, 1, 0, 2'b00, exp_id(w), 1, 0, o);
    total++; if (o.done_ok !== 1'b1 || o.err !== 1'b1 || o.done_sel !== w) begin
      bad++; $display("FAIL timeout_done done=%0d err=%0d sel=%0d want 1/1/%0d", o.done_ok, o.err, o.done_sel, w);
    end
    total++; if (o.n_nobr !== 0 || o.inv !== 0) begin
      bad++; $display("FAIL timeout_protocol nobready=%0d inv=%0d want 0/0", o.n_nobr, o.inv);
    end
    rq1_addr = $urandom; rq1_wdata = {$urandom, $urandom, $urandom, $urandom}; rq1_req = 1'b1;
    w = arb(0, 1);
    txn(0, 0, 0, 2'b00, exp_id(w), 0, 0, o);
    total++; if (o.ack_ok !== 1'b1 || o.sel !== w || o.err !== 1'b0) begin
      bad++; $display("FAIL after_timeout ack=%0d sel=%0d err=%0d want 1/%0d/0", o.ack_ok, o.sel, o.err, w);
    end
  endtask

  task automatic test_random();
    obs_t o; int w;
    bit r0, r1, bd, tmo, xe;
    logic [1:0] resp;
    logic [3:0] eid;
    logic [31:0] ea;
    logic [127:0] ed;
    r0 = 1'b0; r1 = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (!r0 && $urandom_range(0, 1) == 1) begin
        r0 = 1'b1; rq0_addr = $urandom; rq0_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!r1 && $urandom_range(0, 1) == 1) begin
        r1 = 1'b1; rq1_addr = $urandom; rq1_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!r0 && !r1) begin
        r0 = 1'b1; rq0_addr = $urandom; rq0_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      rq0_req = r0; rq1_req = r1;
      w    = arb(r0, r1);
      ea   = (w == 1) ? rq1_addr : rq0_addr;
      ed   = (w == 1) ? rq1_wdata : rq0_wdata;
      eid  = exp_id(w);
      resp = 2'($urandom_range(0, 3));
      bd   = ($urandom_range(0, 4) == 0);
      tmo  = ($urandom_range(0, 9) == 0);
      xe   = resp[1] | bd | tmo;
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp,
          bd ? (eid ^ 4'h3) : eid, tmo, 0, o);
      if (w == 1) r1 = 1'b0; else r0 = 1'b0;
      total++; if (o.sel !== w || o.done_sel !== w) begin
        bad++; $display("FAIL rnd_sel[%0d] got=%0d/%0d want=%0d", n, o.sel, o.done_sel, w);
      end
      total++; if (o.awaddr !== ea || o.awid !== eid || o.nwdata !== ed) begin
        bad++; $display("FAIL rnd_data[%0d] got=%h/%h/%h want=%h/%h/%h", n, o.awaddr, o.awid, o.nwdata, ea, eid, ed);
      end
      total++; if ({o.ack_ok, o.done_ok} !== 2'b11 || o.err !== xe || o.inv !== 0) begin
        bad++; $display("FAIL rnd_resp[%0d] ack=%0d done=%0d err=%0d inv=%0d want 1/1/%0d/0",
                        n, o.ack_ok, o.done_ok, o.err, o.inv, xe);
      end
    end
    rq0_req = 1'b0; rq1_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    obs_t o; int w;
    rq0_addr = 32'h1234_5670; rq0_req = 1'b1;
    w = arb(1, 0);
    #1;
    total++; if (rq0_ack !== 1'b1) begin bad++; $display("FAIL rm_ack got=%0d want=1", rq0_ack); end
    @(posedge clk); #1;
    rq0_req = 1'b0;
    rq1_addr = 32'hCAFE_0000; rq1_wdata = {4{32'h0BAD_F00D}}; rq1_req = 1'b1;
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    #1;
    total++; if (next_rq !== 1'b1) begin bad++; $display("FAIL rm_in_wd got=%0d want=1", next_rq); end
    rst_n = 1'b0;
    #1;
    total++; if (any_out() !== 1'b0) begin bad++; $display("FAIL rm_reset_outs got=%b want=0", any_out()); end
    last_gnt = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    w = arb(0, 1);
    txn(0, 2, 1, 2'b00, exp_id(w), 0, 0, o);
    total++; if (o.ack_ok !== 1'b1 || o.sel !== 1 || o.awaddr !== 32'hCAFE_0000) begin
      bad++; $display("FAIL rm_regrant ack=%0d sel=%0d addr=%h want 1/1/cafe0000", o.ack_ok, o.sel, o.awaddr);
    end
    total++; if (o.done_ok !== 1'b1 || o.done_sel !== 1 || o.err !== 1'b0 || o.inv !== 0) begin
      bad++; $display("FAIL rm_done ok=%0d sel=%0d err=%0d inv=%0d want 1/1/0/0", o.done_ok, o.done_sel, o.err, o.inv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rq0_req = 1'b0; rq1_req = 1'b0;
    rq0_addr = '0; rq1_addr = '0; rq0_wdata = '0; rq1_wdata = '0;
    awready = 1'b0; finish_wd = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    test_reset();
    test_first_tie();
    test_single();
    test_round_robin();
    test_backpressure();
    test_errors();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
